// File: rtl/arb_pkg.sv
// Shared types and constants for the burst arbiter and its winner picker.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  // Never returns 0, so a 2-channel arbiter still gets a 1-bit index.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker: rotates the eligible vector by the pointer,
// priority-encodes the lowest set bit, then rotates the index back.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int IDX_W = clog2_safe(NCH)
) (
  input  logic [NCH-1:0]   elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [NCH-1:0]   win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] NCH_L = (IDX_W+1)'(NCH);

  logic [IDX_W-1:0] base;
  logic [2*NCH-1:0] dbl;
  logic [2*NCH-1:0] shifted;
  logic [NCH-1:0]   rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Fixed-priority mode is simply round-robin anchored at channel 0.
  assign base    = (mode_i == ARB_FIXED) ? '0 : ptr_i;
  assign dbl     = {elig_i, elig_i};
  assign shifted = dbl >> base;
  assign rot     = shifted[NCH-1:0];

  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IDX_W-1:0];
    end
  end

  always_comb begin
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NCH_L) sum = sum - NCH_L;
  end

  assign idx_o = sum[IDX_W-1:0];
  assign any_o = |elig_i;
  assign win_o = any_o ? (NCH'(1) << idx_o) : '0;

endmodule

// File: rtl/arb_rr_burst.sv
// N-channel burst arbiter: grants are held for a programmable length (or until
// the owner drops its request), then the SDRAM FIFO must drain before re-arbitration.
module arb_rr_burst
  import arb_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int IDX_W = clog2_safe(NCH),
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [NCH-1:0]   Req_in,
  input  logic [NCH-1:0]   Mask_in,
  input  logic             Mode,
  input  logic [CNT_W-1:0] Hold_len,
  input  logic             sdram_fifo_empty,
  output logic [NCH-1:0]   Gnt_out,
  output logic [IDX_W-1:0] Gnt_idx,
  output logic             Gnt_valid
);

  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NCH - 1);

  arb_state_e       state_q, state_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NCH-1:0]   elig;
  logic [NCH-1:0]   pick_win;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  assign elig = Req_in & ~Mask_in;

  arb_rr_pick #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .mode_i (Mode),
    .win_o  (pick_win),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_win;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          ptr_d   = (pick_idx == LAST_CH) ? '0 : pick_idx + IDX_W'(1);
          // A zero hold length behaves as one cycle.
          cnt_d   = (Hold_len == '0) ? '0 : Hold_len - CNT_W'(1);
        end
      end
      GRANT: begin
        // Only the owner's raw request can end a grant early; its mask bit is ignored here.
        if (cnt_q == '0 || !Req_in[idx_q]) begin
          state_d = DRAIN;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (sdram_fifo_empty) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Gnt_out   = gnt_q;
  assign Gnt_idx   = idx_q;
  assign Gnt_valid = valid_q;

endmodule

// File: tb/tb_arb_rr_burst.sv
// Directed bench for arb_rr_burst: a cycle model (owner + remaining cycles) checked
// every cycle, plus grant-log checks with hand-computed literal expectations.
module tb_arb_rr_burst;

  localparam int NCH   = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  logic             Clk;
  logic             Reset;
  logic [NCH-1:0]   Req_in;
  logic [NCH-1:0]   Mask_in;
  logic             Mode;
  logic [CNT_W-1:0] Hold_len;
  logic             sdram_fifo_empty;
  logic [NCH-1:0]   Gnt_out;
  logic [IDX_W-1:0] Gnt_idx;
  logic             Gnt_valid;

  arb_rr_burst #(.NCH(NCH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Req_in           (Req_in),
    .Mask_in          (Mask_in),
    .Mode             (Mode),
    .Hold_len         (Hold_len),
    .sdram_fifo_empty (sdram_fifo_empty),
    .Gnt_out          (Gnt_out),
    .Gnt_idx          (Gnt_idx),
    .Gnt_valid        (Gnt_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner channel (-1 = none), cycles of grant left, and whether we are
  // waiting out the drain/guard period.
  int m_owner = -1;
  int m_left  = 0;
  int m_ptr   = 0;
  bit m_drain = 1'b0;

  function automatic int model_pick(input logic [NCH-1:0] e, input int ptr, input logic fixed);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = fixed ? k : (ptr + k) % NCH;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_owner <= -1;
      m_left  <= 0;
      m_ptr   <= 0;
      m_drain <= 1'b0;
    end else if (m_owner >= 0) begin
      if (m_left <= 1 || !Req_in[m_owner]) begin
        m_owner <= -1;
        m_drain <= 1'b1;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (m_drain) begin
      if (sdram_fifo_empty) m_drain <= 1'b0;
    end else if (model_pick(Req_in & ~Mask_in, m_ptr, Mode) >= 0) begin
      m_owner <= model_pick(Req_in & ~Mask_in, m_ptr, Mode);
      m_ptr   <= (model_pick(Req_in & ~Mask_in, m_ptr, Mode) + 1) % NCH;
      m_left  <= (Hold_len == 0) ? 1 : int'(Hold_len);
    end
  end

  // ---------------- per-cycle compare + grant log ----------------
  int g_ch[$];
  int g_start[$];
  int g_len[$];
  int cyc = 0;
  bit prev_valid = 1'b0;

  always @(negedge Clk) begin
    logic [NCH-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (NCH'(1) << m_owner) : '0;
    n_checks += 3;
    if (Gnt_out !== exp_gnt) begin
      n_fail++;
      $display("FAIL cyc%0d Gnt_out: got %h expected %h", cyc, Gnt_out, exp_gnt);
    end
    if (int'(Gnt_idx) !== ((m_owner >= 0) ? m_owner : 0)) begin
      n_fail++;
      $display("FAIL cyc%0d Gnt_idx: got %0d expected %0d", cyc, Gnt_idx, (m_owner >= 0) ? m_owner : 0);
    end
    if (Gnt_valid !== (m_owner >= 0)) begin
      n_fail++;
      $display("FAIL cyc%0d Gnt_valid: got %b expected %b", cyc, Gnt_valid, (m_owner >= 0));
    end
    if (Gnt_valid && !prev_valid) begin
      g_ch.push_back(int'(Gnt_idx));
      g_start.push_back(cyc);
      $display("cyc %0d: grant start ch %0d", cyc, Gnt_idx);
    end else if (!Gnt_valid && prev_valid && g_start.size() > 0) begin
      g_len.push_back(cyc - g_start[g_start.size() - 1]);
      $display("cyc %0d: grant end len %0d", cyc, cyc - g_start[g_start.size() - 1]);
    end
    prev_valid = Gnt_valid;
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic clear_log();
    g_ch.delete();
    g_start.delete();
    g_len.delete();
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (g_ch.size() < n && k < 400) begin step(1); k++; end
    chk({tag, "_timeout_starts"}, (g_ch.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_ends(input int n, input string tag);
    int k = 0;
    while (g_len.size() < n && k < 400) begin step(1); k++; end
    chk({tag, "_timeout_ends"}, (g_len.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!Gnt_valid && k < 100) begin step(1); k++; end
    chk({tag, "_timeout_valid"}, int'(Gnt_valid), 1);
  endtask

  initial begin
    int n_sw;
    int r;
    int k;
    Reset = 1'b1;
    Req_in = '0;
    Mask_in = '0;
    Mode = 1'b0;
    Hold_len = 8'd4;
    sdram_fifo_empty = 1'b1;
    #3;
    chk("reset_gnt", int'(Gnt_out), 0);
    chk("reset_idx", int'(Gnt_idx), 0);
    chk("reset_valid", int'(Gnt_valid), 0);
    step(2);

    // 1: round-robin sweep, hold 4, FIFO always empty
    clear_log();
    Reset = 1'b0;
    Req_in = 16'hFFFF;
    wait_ends(17, "rr");
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("rr_ch%0d", i), g_ch[i], i % 16);
      chk($sformatf("rr_len%0d", i), g_len[i], 4);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("rr_period%0d", i), g_start[i+1] - g_start[i], 6);
    Req_in = '0;
    step(6);
    clear_log();

    // 2: fixed priority on 0x14, then switch to round-robin
    Mode = 1'b1;
    Hold_len = 8'd2;
    Req_in = 16'h0014;
    k = 0;
    while (!(g_ch.size() >= 3 && Gnt_valid && g_len.size() < g_ch.size()) && k < 100) begin step(1); k++; end
    chk("fix_timeout", (g_ch.size() >= 3) ? 1 : 0, 1);
    Mode = 1'b0;
    n_sw = g_ch.size();
    wait_starts(n_sw + 1, "fix");
    for (int i = 0; i < n_sw; i++) chk($sformatf("fix_ch%0d", i), g_ch[i], 2);
    chk("rr_after_fix", g_ch[n_sw], 4);
    Req_in = '0;
    step(6);
    clear_log();

    // 3: early release of channel 5 after 3 grant cycles
    Hold_len = 8'd10;
    Req_in = 16'h0020;
    wait_valid("early");
    step(2);
    Req_in = '0;
    step(3);
    chk("early_ch", g_ch[0], 5);
    chk("early_len", g_len[0], 3);
    chk("early_valid", int'(Gnt_valid), 0);
    step(4);
    clear_log();

    // 4: drain wait with FIFO non-empty for 7+ cycles
    Hold_len = 8'd2;
    Req_in = 16'h0001;
    wait_valid("drain");
    sdram_fifo_empty = 1'b0;
    step(8);
    chk("drain_no_regrant", g_ch.size(), 1);
    chk("drain_valid_low", int'(Gnt_valid), 0);
    sdram_fifo_empty = 1'b1;
    r = cyc;
    wait_starts(2, "drain");
    chk("drain_regrant_delay", g_start[1] - r, 2);
    Req_in = '0;
    step(6);
    clear_log();

    // 5: mask low half, hold 0 treated as 1
    Mask_in = 16'h00FF;
    Req_in = 16'hFFFF;
    Hold_len = 8'd0;
    wait_ends(10, "mask");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("mask_hi%0d", i), (g_ch[i] >= 8) ? 1 : 0, 1);
      chk($sformatf("mask_len%0d", i), g_len[i], 1);
    end
    for (int i = 0; i < 9; i++)
      chk($sformatf("mask_next%0d", i), g_ch[i+1], (g_ch[i] == 15) ? 8 : g_ch[i] + 1);
    Req_in = '0;
    Mask_in = '0;
    step(6);
    clear_log();

    // 6: reset mid-grant, pointer restarts at channel 0
    Hold_len = 8'd8;
    Req_in = 16'hFFFE;
    wait_valid("rst");
    step(2);
    chk("rst_pre_idx_nonzero", (Gnt_idx != 0) ? 1 : 0, 1);
    Reset = 1'b1;
    #1;
    chk("rst_gnt", int'(Gnt_out), 0);
    chk("rst_idx", int'(Gnt_idx), 0);
    chk("rst_valid", int'(Gnt_valid), 0);
    step(2);
    clear_log();
    Req_in = 16'hFFFF;
    Reset = 1'b0;
    wait_starts(1, "rst");
    chk("rst_first_ch", g_ch[0], 0);
    Req_in = '0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_rr_burst.md
Name: arb_rr_burst

Overview:
- Parametrised N-channel burst arbiter; successor to the fixed 16-channel FSM+counter arbiter in front of the SDRAM write path.
- Each grant is held for a programmable burst length, or released early if the master drops its request.
- After each grant it waits for the downstream SDRAM FIFO to drain before re-arbitrating.
- Adds round-robin fairness, a runtime fixed-priority mode, a per-channel request mask, and an encoded grant index.

Parameters:
- NCH, 16, number of requesting channels (2..32).
- IDX_W, $clog2(NCH), width of the encoded grant index.
- CNT_W, 8, width of the burst hold counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req_in  input  NCH  per-channel request, level, held until served.
- Mask_in  input  NCH  1 = channel excluded from arbitration.
- Mode  input  1  0 = round-robin, 1 = fixed priority (bit 0 highest).
- Hold_len  input  CNT_W  grant duration in cycles; 0 is treated as 1.
- sdram_fifo_empty  input  1  downstream FIFO empty (drain done).
- Gnt_out  output  NCH  one-hot grant, registered.
- Gnt_idx  output  IDX_W  encoded index of the granted channel, registered.
- Gnt_valid  output  1  1 while any grant is asserted.

Behaviour:
- Reset: Gnt_out=0, Gnt_idx=0, Gnt_valid=0, state=IDLE, rr pointer=0, counter=0.
- Eligible vector: E = Req_in & ~Mask_in.
- State IDLE:
  - If E != 0, pick a winner, register Gnt_out/Gnt_idx/Gnt_valid on the next edge, and go to GRANT. Request-to-grant latency is 1 cycle.
  - Load counter = max(Hold_len,1)-1; Hold_len is sampled only at this edge.
- Winner selection:
  - Mode=0: first set bit of E at or above the rr pointer, wrapping modulo NCH.
  - Mode=1: lowest set bit of E.
  - The rr pointer updates to (winner+1) mod NCH on every grant in either mode.
- State GRANT:
  - Gnt_out stays constant. The counter decrements each cycle.
  - Exit to DRAIN on the edge where counter==0, or where Req_in[Gnt_idx]==0 (early release).
  - Gnt_out, Gnt_idx and Gnt_valid clear on that edge. Grant duration is therefore exactly max(Hold_len,1) cycles unless released early.
  - Masking the granted channel mid-grant does not end the grant; only its Req does.
- State DRAIN:
  - No grant is asserted.
  - Stay while sdram_fifo_empty==0; go to IDLE on the first edge with sdram_fifo_empty==1.
  - Minimum 1 cycle in DRAIN (guard cycle), even if the FIFO is already empty.
- Back-to-back minimum: grant end -> DRAIN (>=1) -> IDLE (1) -> next grant. Gnt_valid has at least 2 low cycles between grants.
- Simultaneous events:
  - Req drop coincident with counter==0 is a single exit; no double count.
  - Mode or Mask changes take effect only at the next IDLE decision.
- Reset asserted mid-grant drops the grant asynchronously, with no drain wait.
- Invariants: Gnt_out is one-hot or zero; Gnt_valid == |Gnt_out; Gnt_out[Gnt_idx]==1 whenever Gnt_valid.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT, DRAIN}.
  - Mode encodings ARB_RR=0, ARB_FIXED=1.
  - Function clog2_safe.
- Sub-module arb_rr_pick (combinational):
  - Inputs: E, pointer, Mode.
  - Outputs: one-hot winner, index, any.
  - Implementation: double-width rotate/priority-encode.
- The FSM, burst counter and pointer register stay in arb_rr_burst.

Test Plan:
- NCH=16, Mode=0, Hold_len=4, Req_in=16'hFFFF held, sdram_fifo_empty=1 -> grants to 0,1,2,...,15,0 in order, each exactly 4 cycles, 2 idle cycles between grants.
- Mode=1, Req_in=16'h0014 held -> channel 2 granted every time, never channel 4; switch Mode=0 -> next grant goes to channel 4.
- Hold_len=10, Req_in[5] dropped 3 cycles into its grant -> Gnt_out clears on that edge after 3 grant cycles; DRAIN is entered.
- After a grant, hold sdram_fifo_empty=0 for 7 cycles -> Gnt_valid stays 0 until 1 cycle after empty rises; the next grant comes 2 cycles after that.
- Mask_in=16'h00FF, Req_in=16'hFFFF -> only channels 8..15 are granted; Hold_len=0 -> each grant lasts 1 cycle.
- Assert Reset mid-GRANT -> Gnt_out=0 and Gnt_idx=0 immediately; after release, the first grant goes to channel 0 (pointer reset).
